// File: rtl/fft_stage_fold.sv
// ---------------------------------------------------------------------------
// fft_stage_fold
//
// Folded radix-2 FFT stage. A whole frame of P_POINTS complex samples and
// P_POINTS/2 twiddles is captured in one transfer. The stage then runs
// P_BFLY butterflies per clock over N/(2*P_BFLY) cycles and presents the
// whole result frame until downstream accepts it.
//
// Butterfly k pairs slot top = (k/P_SPAN)*2*P_SPAN + k%P_SPAN with
// slot bottom = top + P_SPAN, and uses twiddle slot k:
//   T = W*B (Q1.(P_WIDDLE_BITS-2), rounded half-up, arithmetic shift)
//   out[top] = A + T, out[bottom] = A - T
//
// Optional feature macro: FFT_STAGE_SAT_EN
//   defined   : results saturate to P_OUTPUT_BITS, port o_sat reports clipping
//   undefined : results wrap modulo 2^P_OUTPUT_BITS, no o_sat port
//
// Ports
//   CLK       in   rising-edge clock
//   RST       in   asynchronous active-low reset
//   i_valid   in   input frame valid
//   o_ready   out  high only while idle (frame can be accepted)
//   i_data    in   N samples, sample n = {im,re} at slot n, slot 0 in LSBs
//   i_widdle  in   N/2 twiddles, twiddle k = {im,re}
//   o_valid   out  output frame valid
//   i_ready   in   downstream accepts output frame
//   o_data    out  N results, same slot order as i_data
//   o_sat     out  sticky per-frame saturation flag (FFT_STAGE_SAT_EN only)
// ---------------------------------------------------------------------------
module fft_stage_fold #(
   parameter int P_POINTS      = 32,
   parameter int P_SPAN        = 2,
   parameter int P_BFLY        = 4,
   parameter int P_INPUT_BITS  = 9,
   parameter int P_OUTPUT_BITS = 16,
   parameter int P_WIDDLE_BITS = 8
) (
   input  logic                                       CLK,
   input  logic                                       RST,
   input  logic                                       i_valid,
   output logic                                       o_ready,
   input  logic [P_POINTS*2*P_INPUT_BITS-1:0]         i_data,
   input  logic [(P_POINTS/2)*2*P_WIDDLE_BITS-1:0]    i_widdle,
   output logic                                       o_valid,
   input  logic                                       i_ready,
   output logic [P_POINTS*2*P_OUTPUT_BITS-1:0]        o_data
`ifdef FFT_STAGE_SAT_EN
   ,
   output logic                                       o_sat
`endif
);

   localparam int IW    = P_INPUT_BITS;
   localparam int WW    = P_WIDDLE_BITS;
   localparam int OW    = P_OUTPUT_BITS;
   localparam int C     = P_POINTS / (2 * P_BFLY);
   localparam int CW    = (C > 1) ? $clog2(C) : 1;
   localparam int IDXW  = $clog2(P_POINTS);
   localparam int PW    = IW + WW;
   // Sum width wide enough that A +/- T never overflows before folding.
   localparam int SW    = (PW + 2 > OW + 1) ? PW + 2 : OW + 1;
   localparam int RH    = 2 ** (WW - 3);
   localparam int RSH   = WW - 2;

`ifdef FFT_STAGE_SAT_EN
   localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_OUT     = 2'd2
   } state_t;

   state_t                                   state_q;
   state_t                                   state_d;
   logic [CW-1:0]                            batch_q;
   logic [P_POINTS*2*IW-1:0]                 frame_p0;
   logic [(P_POINTS/2)*2*WW-1:0]             widdle_p0;

   logic [IDXW-1:0]                          lane_top    [P_BFLY];
   logic [IDXW-1:0]                          lane_bot    [P_BFLY];
   logic signed [OW-1:0]                     lane_top_re [P_BFLY];
   logic signed [OW-1:0]                     lane_top_im [P_BFLY];
   logic signed [OW-1:0]                     lane_bot_re [P_BFLY];
   logic signed [OW-1:0]                     lane_bot_im [P_BFLY];
`ifdef FFT_STAGE_SAT_EN
   logic [P_BFLY-1:0]                        lane_clip;
`endif

   // Twiddle product rounding: add half an LSB of the result, then shift
   // arithmetically so negative values round toward +inf on ties.
   function automatic logic signed [PW:0] round_tw(input logic signed [PW:0] x);
      return (x + (PW+1)'(RH)) >>> RSH;
   endfunction

   // Reduce a full-precision sum to the output width.
   function automatic logic signed [OW-1:0] fold_out(input logic signed [SW-1:0] x);
`ifdef FFT_STAGE_SAT_EN
      if (x > MAXV) return MAXV[OW-1:0];
      if (x < MINV) return MINV[OW-1:0];
      return x[OW-1:0];
`else
      return x[OW-1:0];
`endif
   endfunction

`ifdef FFT_STAGE_SAT_EN
   function automatic logic is_clip(input logic signed [SW-1:0] x);
      return (x > MAXV) || (x < MINV);
   endfunction
`endif

   // Butterfly lanes: lane j handles butterfly k = batch*P_BFLY + j.
   for (genvar j = 0; j < P_BFLY; j++) begin : g_lane
      int                       k;
      logic [IDXW-1:0]          top;
      logic [IDXW-1:0]          bot;
      logic signed [IW-1:0]     ar, ai, br, bi;
      logic signed [WW-1:0]     wr, wi;
      logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
      logic signed [PW:0]       x_re, x_im, t_re, t_im;
      logic signed [SW-1:0]     s_top_re, s_top_im, s_bot_re, s_bot_im;

      assign k    = int'(batch_q) * P_BFLY + j;
      assign top  = IDXW'((k / P_SPAN) * 2 * P_SPAN + (k % P_SPAN));
      assign bot  = top + IDXW'(P_SPAN);

      assign ar   = frame_p0[int'(top)*2*IW      +: IW];
      assign ai   = frame_p0[(int'(top)*2+1)*IW  +: IW];
      assign br   = frame_p0[int'(bot)*2*IW      +: IW];
      assign bi   = frame_p0[(int'(bot)*2+1)*IW  +: IW];
      assign wr   = widdle_p0[k*2*WW             +: WW];
      assign wi   = widdle_p0[(k*2+1)*WW         +: WW];

      assign p_rr = PW'(br) * PW'(wr);
      assign p_ii = PW'(bi) * PW'(wi);
      assign p_ri = PW'(br) * PW'(wi);
      assign p_ir = PW'(bi) * PW'(wr);
      assign x_re = (PW+1)'(p_rr) - (PW+1)'(p_ii);
      assign x_im = (PW+1)'(p_ri) + (PW+1)'(p_ir);
      assign t_re = round_tw(x_re);
      assign t_im = round_tw(x_im);

      assign s_top_re = SW'(ar) + SW'(t_re);
      assign s_top_im = SW'(ai) + SW'(t_im);
      assign s_bot_re = SW'(ar) - SW'(t_re);
      assign s_bot_im = SW'(ai) - SW'(t_im);

      assign lane_top[j]    = top;
      assign lane_bot[j]    = bot;
      assign lane_top_re[j] = fold_out(s_top_re);
      assign lane_top_im[j] = fold_out(s_top_im);
      assign lane_bot_re[j] = fold_out(s_bot_re);
      assign lane_bot_im[j] = fold_out(s_bot_im);
`ifdef FFT_STAGE_SAT_EN
      assign lane_clip[j]   = is_clip(s_top_re) | is_clip(s_top_im) |
                              is_clip(s_bot_re) | is_clip(s_bot_im);
`endif
   end

   // ---- control FSM: state register ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- control FSM: next state and handshake outputs ----
   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) state_d = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            if (batch_q == CW'(C - 1)) state_d = ST_OUT;
         end
         ST_OUT: begin
            o_valid = 1'b1;
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---- stage p0: frame capture, batch writes into the result frame ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         frame_p0  <= '0;
         widdle_p0 <= '0;
         batch_q   <= '0;
         o_data    <= '0;
`ifdef FFT_STAGE_SAT_EN
         o_sat     <= 1'b0;
`endif
      end else begin
         if (state_q == ST_IDLE && i_valid) begin
            frame_p0  <= i_data;
            widdle_p0 <= i_widdle;
            batch_q   <= '0;
`ifdef FFT_STAGE_SAT_EN
            o_sat     <= 1'b0;
`endif
         end else if (state_q == ST_COMPUTE) begin
            batch_q <= batch_q + CW'(1);
            for (int j = 0; j < P_BFLY; j++) begin
               o_data[int'(lane_top[j])*2*OW     +: OW] <= lane_top_re[j];
               o_data[(int'(lane_top[j])*2+1)*OW +: OW] <= lane_top_im[j];
               o_data[int'(lane_bot[j])*2*OW     +: OW] <= lane_bot_re[j];
               o_data[(int'(lane_bot[j])*2+1)*OW +: OW] <= lane_bot_im[j];
            end
`ifdef FFT_STAGE_SAT_EN
            o_sat <= o_sat | (|lane_clip);
`endif
         end
      end
   end

endmodule

// File: tb/tb_fft_stage_fold.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_fold
//
// Three instances share one clock, reset and input bus:
//   dut_a : default parameters
//   dut_b : P_OUTPUT_BITS = 10 (output folding)
//   dut_c : P_BFLY = 16, P_SPAN = 16 (single-cycle compute)
// Expected frames come from an integer reference model of the butterfly
// equations.
// ---------------------------------------------------------------------------
module tb_fft_stage_fold;

   localparam int N  = 32;
   localparam int IB = 9;
   localparam int WB = 8;
`ifdef FFT_STAGE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                       CLK = 1'b0;
   logic                       RST;
   logic [N*2*IB-1:0]          data;
   logic [(N/2)*2*WB-1:0]      widdle;

   logic a_iv, a_or, a_ov, a_ir;
   logic b_iv, b_or, b_ov, b_ir;
   logic c_iv, c_or, c_ov, c_ir;
   logic [N*2*16-1:0]          a_od;
   logic [N*2*10-1:0]          b_od;
   logic [N*2*16-1:0]          c_od;
`ifdef FFT_STAGE_SAT_EN
   logic a_sat, b_sat, c_sat;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   int in_re [N];
   int in_im [N];
   int w_re  [N/2];
   int w_im  [N/2];
   int exp_re[N];
   int exp_im[N];
   bit exp_sat;

   always #5 CLK = ~CLK;

   fft_stage_fold dut_a (
      .CLK(CLK), .RST(RST), .i_valid(a_iv), .o_ready(a_or), .i_data(data),
      .i_widdle(widdle), .o_valid(a_ov), .i_ready(a_ir), .o_data(a_od)
`ifdef FFT_STAGE_SAT_EN
      , .o_sat(a_sat)
`endif
   );

   fft_stage_fold #(.P_OUTPUT_BITS(10)) dut_b (
      .CLK(CLK), .RST(RST), .i_valid(b_iv), .o_ready(b_or), .i_data(data),
      .i_widdle(widdle), .o_valid(b_ov), .i_ready(b_ir), .o_data(b_od)
`ifdef FFT_STAGE_SAT_EN
      , .o_sat(b_sat)
`endif
   );

   fft_stage_fold #(.P_BFLY(16), .P_SPAN(16)) dut_c (
      .CLK(CLK), .RST(RST), .i_valid(c_iv), .o_ready(c_or), .i_data(data),
      .i_widdle(widdle), .o_valid(c_ov), .i_ready(c_ir), .o_data(c_od)
`ifdef FFT_STAGE_SAT_EN
      , .o_sat(c_sat)
`endif
   );

   // ---- reference model ----
   function automatic longint fold(input longint v, input int ob);
      longint m;
      longint h;
      longint r;
      m = 64'sd1 <<< ob;
      h = m / 2;
      if (SAT) begin
         if (v > h - 1) return h - 1;
         if (v < -h) return -h;
         return v;
      end
      r = v % m;
      if (r < 0) r += m;
      if (r >= h) r -= m;
      return r;
   endfunction

   task automatic model(input int span, input int ob);
      longint half, h, tr, ti;
      longint v[4];
      int top, bot;
      half = 64'sd1 <<< (WB - 3);
      h = 64'sd1 <<< (ob - 1);
      exp_sat = 1'b0;
      for (int k = 0; k < N/2; k++) begin
         top = (k / span) * 2 * span + (k % span);
         bot = top + span;
         tr = (longint'(in_re[bot]) * w_re[k] - longint'(in_im[bot]) * w_im[k] + half) >>> (WB - 2);
         ti = (longint'(in_re[bot]) * w_im[k] + longint'(in_im[bot]) * w_re[k] + half) >>> (WB - 2);
         v[0] = in_re[top] + tr;
         v[1] = in_im[top] + ti;
         v[2] = in_re[top] - tr;
         v[3] = in_im[top] - ti;
         for (int i = 0; i < 4; i++)
            if (v[i] > h - 1 || v[i] < -h) exp_sat = 1'b1;
         exp_re[top] = int'(fold(v[0], ob));
         exp_im[top] = int'(fold(v[1], ob));
         exp_re[bot] = int'(fold(v[2], ob));
         exp_im[bot] = int'(fold(v[3], ob));
      end
   endtask

   // ---- stimulus helpers ----
   task automatic pack();
      for (int n = 0; n < N; n++) begin
         data[n*2*IB +: IB]     = IB'(in_re[n]);
         data[(n*2+1)*IB +: IB] = IB'(in_im[n]);
      end
      for (int k = 0; k < N/2; k++) begin
         widdle[k*2*WB +: WB]     = WB'(w_re[k]);
         widdle[(k*2+1)*WB +: WB] = WB'(w_im[k]);
      end
   endtask

   task automatic fill_const(input int re, input int im, input int wr, input int wi);
      for (int n = 0; n < N; n++) begin in_re[n] = re; in_im[n] = im; end
      for (int k = 0; k < N/2; k++) begin w_re[k] = wr; w_im[k] = wi; end
   endtask

   task automatic fill_random();
      for (int n = 0; n < N; n++) begin
         in_re[n] = int'($urandom_range(0, 511)) - 256;
         in_im[n] = int'($urandom_range(0, 511)) - 256;
      end
      for (int k = 0; k < N/2; k++) begin
         w_re[k] = int'($urandom_range(0, 255)) - 128;
         w_im[k] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   function automatic logic ov(input int sel);
      case (sel)
         0: return a_ov;
         1: return b_ov;
         default: return c_ov;
      endcase
   endfunction

   function automatic int got(input int sel, input int idx);
      case (sel)
         0: return int'($signed(a_od[idx*16 +: 16]));
         1: return int'($signed(b_od[idx*10 +: 10]));
         default: return int'($signed(c_od[idx*16 +: 16]));
      endcase
   endfunction

   task automatic set_iv(input int sel, input logic v);
      case (sel)
         0: a_iv = v;
         1: b_iv = v;
         default: c_iv = v;
      endcase
   endtask

   task automatic set_ir(input int sel, input logic v);
      case (sel)
         0: a_ir = v;
         1: b_ir = v;
         default: c_ir = v;
      endcase
   endtask

   // Offer one frame, return edges from accept to first o_valid (-1 on timeout).
   task automatic send(input int sel, output int lat);
      @(negedge CLK);
      pack();
      set_iv(sel, 1'b1);
      @(posedge CLK);
      #1 set_iv(sel, 1'b0);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         #1;
         if (ov(sel)) begin lat = i; break; end
      end
   endtask

   task automatic release_out(input int sel);
      @(negedge CLK);
      set_ir(sel, 1'b1);
      @(posedge CLK);
      #1 set_ir(sel, 1'b0);
   endtask

   // ---- tests ----
   task automatic test_reset();
      RST = 1'b0;
      a_iv = 0; b_iv = 0; c_iv = 0; a_ir = 0; b_ir = 0; c_ir = 0;
      data = '0; widdle = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid got %b want 0", a_ov); end
      n_cmp++; if (a_od !== '0) begin n_bad++; $display("FAIL reset_odata got %h want 0", a_od); end
      RST = 1'b1;
      @(posedge CLK);
      #1;
      n_cmp++; if (a_or !== 1'b1) begin n_bad++; $display("FAIL reset_oready got %b want 1", a_or); end
      n_cmp++; if (b_ov !== 1'b0 || c_ov !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid_bc got %b%b want 00", b_ov, c_ov); end
   endtask

   task automatic test_unity();
      int lat;
      bit bad;
      fill_const(1, 0, 64, 0);
      send(0, lat);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL unity_latency got %0d want 4", lat); end
      model(2, 16);
      bad = 0;
      for (int n = 0; n < N; n++)
         if (got(0, 2*n) !== exp_re[n] || got(0, 2*n+1) !== exp_im[n]) begin
            if (!bad) $display("FAIL unity_frame slot %0d got %0d,%0d want %0d,%0d", n, got(0, 2*n), got(0, 2*n+1), exp_re[n], exp_im[n]);
            bad = 1;
         end
      n_cmp++; if (bad) n_bad++;
      n_cmp++; if (got(0, 0) !== 2 || got(0, 4) !== 0) begin n_bad++; $display("FAIL unity_top_bottom got %0d,%0d want 2,0", got(0, 0), got(0, 4)); end
      release_out(0);
      n_cmp++; if (a_ov !== 1'b0 || a_or !== 1'b1) begin n_bad++; $display("FAIL unity_transfer got v%b r%b want v0 r1", a_ov, a_or); end
   endtask

   task automatic test_rotate();
      int lat;
      bit bad;
      fill_const(0, 0, 0, -64);
      for (int n = 0; n < N; n++) in_re[n] = ((n & 2) != 0) ? 3 : 0;
      send(0, lat);
      model(2, 16);
      bad = 0;
      for (int n = 0; n < N; n++)
         if (got(0, 2*n) !== exp_re[n] || got(0, 2*n+1) !== exp_im[n]) begin
            if (!bad) $display("FAIL rotate_frame slot %0d got %0d,%0d want %0d,%0d", n, got(0, 2*n), got(0, 2*n+1), exp_re[n], exp_im[n]);
            bad = 1;
         end
      n_cmp++; if (bad) n_bad++;
      n_cmp++; if (got(0, 0) !== 0 || got(0, 1) !== -3) begin n_bad++; $display("FAIL rotate_top got %0d,%0d want 0,-3", got(0, 0), got(0, 1)); end
      n_cmp++; if (got(0, 4) !== 0 || got(0, 5) !== 3) begin n_bad++; $display("FAIL rotate_bottom got %0d,%0d want 0,3", got(0, 4), got(0, 5)); end
      release_out(0);
   endtask

   task automatic test_random();
      int lat;
      bit bad;
      for (int f = 0; f < 4; f++) begin
         fill_random();
         send(0, lat);
         n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL random_latency frame %0d got %0d want 4", f, lat); end
         model(2, 16);
         bad = 0;
         for (int n = 0; n < N; n++)
            if (got(0, 2*n) !== exp_re[n] || got(0, 2*n+1) !== exp_im[n]) begin
               if (!bad) $display("FAIL random_frame %0d slot %0d got %0d,%0d want %0d,%0d", f, n, got(0, 2*n), got(0, 2*n+1), exp_re[n], exp_im[n]);
               bad = 1;
            end
         n_cmp++; if (bad) n_bad++;
`ifdef FFT_STAGE_SAT_EN
         n_cmp++; if (a_sat !== exp_sat) begin n_bad++; $display("FAIL random_sat frame %0d got %b want %b", f, a_sat, exp_sat); end
`endif
         release_out(0);
      end
   endtask

   task automatic test_back_pressure();
      int lat;
      bit bad;
      logic [N*2*16-1:0] snap;
      fill_random();
      send(0, lat);
      snap = a_od;
      fill_random();
      @(negedge CLK);
      pack();
      a_iv = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
         if (a_ov !== 1'b1 || a_or !== 1'b0 || a_od !== snap) bad = 1;
      end
      n_cmp++; if (bad) begin n_bad++; $display("FAIL hold_stable got v%b r%b want v1 r0 with unchanged data", a_ov, a_or); end
      @(negedge CLK);
      a_ir = 1'b1;
      @(posedge CLK);
      #1;
      a_ir = 1'b0;
      a_iv = 1'b0;
      n_cmp++; if (a_ov !== 1'b0 || a_or !== 1'b1) begin n_bad++; $display("FAIL hold_transfer got v%b r%b want v0 r1", a_ov, a_or); end
      @(posedge CLK);
      #1;
      n_cmp++; if (a_od !== snap || a_ov !== 1'b0) begin n_bad++; $display("FAIL hold_after_transfer got v%b data_changed %b want v0 data_changed 0", a_ov, a_od !== snap); end
      send(0, lat);
      model(2, 16);
      bad = 0;
      for (int n = 0; n < N; n++)
         if (got(0, 2*n) !== exp_re[n] || got(0, 2*n+1) !== exp_im[n]) bad = 1;
      n_cmp++; if (bad || lat !== 4) begin n_bad++; $display("FAIL hold_next_frame got lat %0d mismatch %b want lat 4 mismatch 0", lat, bad); end
      release_out(0);
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      bit bad;
      fill_const(1, 0, 64, 0);
      @(negedge CLK);
      pack();
      a_iv = 1'b1;
      @(posedge CLK);
      #1 a_iv = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      n_cmp++; if (a_ov !== 1'b0 || a_od !== '0) begin n_bad++; $display("FAIL midreset_clear got v%b data %h want v0 data 0", a_ov, a_od); end
      @(negedge CLK);
      RST = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK);
         #1;
         if (a_ov) seen++;
      end
      n_cmp++; if (seen !== 0 || a_or !== 1'b1) begin n_bad++; $display("FAIL midreset_no_emit got valid_cycles %0d ready %b want 0 and 1", seen, a_or); end
      fill_random();
      send(0, lat);
      model(2, 16);
      bad = 0;
      for (int n = 0; n < N; n++)
         if (got(0, 2*n) !== exp_re[n] || got(0, 2*n+1) !== exp_im[n]) bad = 1;
      n_cmp++; if (bad || lat !== 4) begin n_bad++; $display("FAIL midreset_next_frame got lat %0d mismatch %b want lat 4 mismatch 0", lat, bad); end
      release_out(0);
   endtask

   task automatic test_output_fold();
      int lat;
      bit bad;
      int want_top;
      fill_const(255, 0, 127, 0);
      send(1, lat);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL fold_latency got %0d want 4", lat); end
      want_top = SAT ? 511 : -263;
      n_cmp++; if (got(1, 0) !== want_top) begin n_bad++; $display("FAIL fold_top_re got %0d want %0d", got(1, 0), want_top); end
      n_cmp++; if (got(1, 4) !== -251) begin n_bad++; $display("FAIL fold_bottom_re got %0d want -251", got(1, 4)); end
`ifdef FFT_STAGE_SAT_EN
      n_cmp++; if (b_sat !== 1'b1) begin n_bad++; $display("FAIL fold_sat_flag got %b want 1", b_sat); end
`endif
      model(2, 10);
      bad = 0;
      for (int n = 0; n < N; n++)
         if (got(1, 2*n) !== exp_re[n] || got(1, 2*n+1) !== exp_im[n]) begin
            if (!bad) $display("FAIL fold_frame slot %0d got %0d,%0d want %0d,%0d", n, got(1, 2*n), got(1, 2*n+1), exp_re[n], exp_im[n]);
            bad = 1;
         end
      n_cmp++; if (bad) n_bad++;
      release_out(1);
      n_cmp++; if (b_ov !== 1'b0 || b_or !== 1'b1) begin n_bad++; $display("FAIL fold_transfer got v%b r%b want v0 r1", b_ov, b_or); end
   endtask

   task automatic test_wide();
      int lat;
      bit bad;
      for (int f = 0; f < 2; f++) begin
         fill_random();
         send(2, lat);
         n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wide_latency frame %0d got %0d want 1", f, lat); end
         model(16, 16);
         bad = 0;
         for (int n = 0; n < N; n++)
            if (got(2, 2*n) !== exp_re[n] || got(2, 2*n+1) !== exp_im[n]) begin
               if (!bad) $display("FAIL wide_frame %0d slot %0d got %0d,%0d want %0d,%0d", f, n, got(2, 2*n), got(2, 2*n+1), exp_re[n], exp_im[n]);
               bad = 1;
            end
         n_cmp++; if (bad) n_bad++;
         release_out(2);
      end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_rotate();
      test_random();
      test_back_pressure();
      test_reset_mid();
      test_output_fold();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
